activation_pipe: RTL and testbench
==================================

ACTIVATION_PIPE -- requirements
Module: activation_pipe

Interface
REQ-001 SHALL have parameter DESIGN_SIZE, default 8, giving the number of lanes per vector and the vectors per tile.
REQ-002 SHALL have parameter DWIDTH, default 8, giving the width of each signed two's-complement lane.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port enable_activation, input, 1 bit; 1 = process, 0 = bypass and clear.
REQ-006 SHALL have port in_data_available, input, 1 bit, valid qualifier for inp_data (driven by the upstream pool stage's out_data_available).
REQ-007 SHALL have port activation_type, input, 2 bits: 0 ReLU, 1 leaky ReLU, 2 clamped ReLU, 3 identity.
REQ-008 SHALL have port clamp_value, input, DWIDTH bits, upper bound for mode 2; MSB is ignored (bound is always non-negative).
REQ-009 SHALL have port inp_data, input, DESIGN_SIZE*DWIDTH bits; lane k occupies bits [k*DWIDTH +: DWIDTH].
REQ-010 SHALL have port out_data, output, DESIGN_SIZE*DWIDTH bits, same lane packing as inp_data.
REQ-011 SHALL have port out_data_available, output, 1 bit, valid qualifier for out_data.
REQ-012 SHALL have port done_activation, output, 1 bit, tile-complete flag.

Function
REQ-013 SHALL, when enable_activation=0, drive out_data=inp_data, out_data_available=in_data_available and done_activation=1 combinationally.
REQ-014 SHALL, when enable_activation=1, implement a 2-stage register pipeline: vector accepted at edge N (in_data_available=1) appears on out_data with out_data_available=1 during the cycle after edge N+1.
REQ-015 SHALL sample activation_type and clamp_value with each accepted vector in stage 1; changes mid-stream affect only subsequently accepted vectors.
REQ-016 SHALL, in mode 0, output 0 for x<0 and x otherwise.
REQ-017 SHALL, in mode 1, output x for x>=0 and x>>>3 (arithmetic shift, floor toward negative infinity) for x<0.
REQ-018 SHALL, in mode 2, output 0 for x<0, the masked clamp value B for x>B, and x otherwise.
REQ-019 SHALL, in mode 3, output x unchanged.
REQ-020 SHALL produce every result at DWIDTH bits with no overflow possible; no saturation logic is required.
REQ-021 SHALL treat in_data_available=0 as a bubble: the stage valids propagate 0, stored data is held, and the output count is unchanged (pipeline is not flushed).
REQ-022 SHALL keep an output counter of vectors emitted with out_data_available=1; done_activation SHALL rise in the cycle the DESIGN_SIZE-th vector is presented and stay 1 (sticky) until reset or enable_activation=0.
REQ-023 SHALL, after done_activation=1, continue to process further vectors without wrapping the counter or re-pulsing done.
REQ-024 SHALL, when enable_activation falls mid-tile, clear both stages, the counter and done at the next edge; in-flight vectors are discarded.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, clear stage valids, stage data, the counter and done; with enable_activation=1, out_data=0, out_data_available=0 and done_activation=0 in the following cycle.
REQ-026 SHALL give reset priority over all other inputs; in_data_available asserted in the same cycle as reset SHALL NOT be accepted.

Structure
REQ-027 SHALL define the activation_type encodings (ACT_RELU, ACT_LEAKY, ACT_CLAMP, ACT_IDENTITY) and LEAKY_SHIFT=3 as constants in the shared design package/defines.
REQ-028 SHALL instantiate one sub-module, activation_lane, per lane, performing the combinational single-DWIDTH-value function; pipeline registers and the counter belong to activation_pipe.

Verification (DESIGN_SIZE=4, DWIDTH=8)
REQ-029 SHALL cover mode 0, lanes {-5, 0, 7, -128} -> {0, 0, 7, 0} exactly 2 cycles after acceptance.
REQ-030 SHALL cover mode 1, lanes {-16, -1, 9, -128} -> {-2, -1, 9, -16}.
REQ-031 SHALL cover mode 2 with clamp_value=0x86 (B=6), lanes {10, 6, -3, 5} -> {6, 6, 0, 5}.
REQ-032 SHALL cover 4 vectors with 2 bubble cycles inserted after vector 2 -> done_activation rises with the 4th output, exactly 4 valid outputs, and no output during bubbles.
REQ-033 SHALL cover enable_activation dropped after 2 accepted vectors, then restored, then 4 vectors sent -> bypass outputs equal inputs, done=1 while disabled, and done rises only on the 4th new vector.
REQ-034 SHALL cover reset asserted in the same cycle as in_data_available=1 -> no output appears and the counter remains 0.

Source files
------------

// File: rtl/activation_pipe_pkg.sv
// Shared activation encodings and pipeline constants for activation_pipe.
// Imported by the lane function and the pipeline top.
package activation_pipe_pkg;

    typedef enum logic [1:0] {
        ACT_RELU     = 2'd0,
        ACT_LEAKY    = 2'd1,
        ACT_CLAMP    = 2'd2,
        ACT_IDENTITY = 2'd3
    } act_type_e;

    // Leaky slope is 1/8, realised as an arithmetic right shift.
    localparam int LEAKY_SHIFT = 3;

    // Output counter width able to hold the value DESIGN_SIZE without wrapping.
    function automatic int cnt_width(input int design_size);
        return (design_size < 2) ? 1 : $clog2(design_size + 1);
    endfunction

endpackage

// File: rtl/activation_pipe_if.sv
// Vector bus into and out of activation_pipe; master drives vectors and mode, slave returns results.
// No ready path: the upstream pool stage streams freely and bubbles are marked by in_data_available=0.
interface activation_pipe_if #(
    parameter int DESIGN_SIZE = 8,
    parameter int DWIDTH      = 8
);
    logic                          enable_activation;
    logic                          in_data_available;
    logic [1:0]                    activation_type;
    logic [DWIDTH-1:0]             clamp_value;
    logic [DESIGN_SIZE*DWIDTH-1:0] inp_data;
    logic [DESIGN_SIZE*DWIDTH-1:0] out_data;
    logic                          out_data_available;
    logic                          done_activation;

    modport master (
        output enable_activation, in_data_available, activation_type, clamp_value, inp_data,
        input  out_data, out_data_available, done_activation
    );

    modport slave (
        input  enable_activation, in_data_available, activation_type, clamp_value, inp_data,
        output out_data, out_data_available, done_activation
    );
endinterface

// File: rtl/activation_pipe_lane.sv
// Single-lane activation function (ReLU / leaky / clamped / identity); purely combinational.
// Zero latency, no backpressure: the owning pipeline registers around it.
module activation_lane
    import activation_pipe_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic signed [DWIDTH-1:0] x,
    input  act_type_e                act_type,
    input  logic        [DWIDTH-1:0] clamp_value,
    output logic signed [DWIDTH-1:0] y
);
    // The clamp bound is forced non-negative so it never undercuts the ReLU floor.
    logic signed [DWIDTH-1:0] bound;
    assign bound = {1'b0, clamp_value[DWIDTH-2:0]};

    always_comb begin
        y = x;
        case (act_type)
            ACT_RELU: begin
                if (x < 0) y = '0;
            end
            ACT_LEAKY: begin
                if (x < 0) y = x >>> LEAKY_SHIFT;
            end
            ACT_CLAMP: begin
                if (x < 0)          y = '0;
                else if (x > bound) y = bound;
            end
            default: y = x;
        endcase
    end

endmodule

// File: rtl/activation_pipe.sv
// Two-stage activation pipeline with a sticky tile-complete flag; bypasses combinationally when disabled.
// Latency 2 edges from acceptance; no backpressure, in_data_available=0 inserts a bubble.
module activation_pipe
    import activation_pipe_pkg::*;
#(
    parameter int DESIGN_SIZE = 8,
    parameter int DWIDTH      = 8
) (
    input logic              clk,
    input logic              reset,
    activation_pipe_if.slave bus
);
    localparam int VW = DESIGN_SIZE * DWIDTH;
    localparam int CW = cnt_width(DESIGN_SIZE);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DESIGN_SIZE);
    localparam logic [CW-1:0] CNT_LAST = CW'(DESIGN_SIZE - 1);

    logic              s1_vld;
    logic [VW-1:0]     s1_dat;
    act_type_e         s1_type;
    logic [DWIDTH-1:0] s1_clamp;
    logic              s2_vld;
    logic [VW-1:0]     s2_dat;
    logic [VW-1:0]     act_dat;
    logic [CW-1:0]     out_cnt;
    logic              done;

    for (genvar k = 0; k < DESIGN_SIZE; k++) begin : g_lane
        activation_lane #(.DWIDTH(DWIDTH)) u_lane (
            .x           (s1_dat[k*DWIDTH +: DWIDTH]),
            .act_type    (s1_type),
            .clamp_value (s1_clamp),
            .y           (act_dat[k*DWIDTH +: DWIDTH])
        );
    end

    // Disabling acts as a flush: in-flight vectors and the tile count are discarded.
    always_ff @(posedge clk) begin
        if (reset || !bus.enable_activation) begin
            s1_vld   <= 1'b0;
            s1_dat   <= '0;
            s1_type  <= ACT_RELU;
            s1_clamp <= '0;
            s2_vld   <= 1'b0;
            s2_dat   <= '0;
            out_cnt  <= '0;
            done     <= 1'b0;
        end else begin
            s1_vld <= bus.in_data_available;
            if (bus.in_data_available) begin
                s1_dat   <= bus.inp_data;
                s1_type  <= act_type_e'(bus.activation_type);
                s1_clamp <= bus.clamp_value;
            end
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_dat <= act_dat;
                // Count saturates so done never re-pulses on later vectors.
                if (out_cnt != CNT_MAX)  out_cnt <= out_cnt + 1'b1;
                if (out_cnt == CNT_LAST) done    <= 1'b1;
            end
        end
    end

    assign bus.out_data           = bus.enable_activation ? s2_dat : bus.inp_data;
    assign bus.out_data_available = bus.enable_activation ? s2_vld : bus.in_data_available;
    assign bus.done_activation    = bus.enable_activation ? done   : 1'b1;

endmodule

// File: tb/tb_activation_pipe.sv
// Randomized and directed bench for activation_pipe against a queue-based reference model.
module tb_activation_pipe;
    localparam int DS = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    activation_pipe_if #(.DESIGN_SIZE(DS), .DWIDTH(DW)) bus ();
    activation_pipe #(.DESIGN_SIZE(DS), .DWIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          due;
        logic [31:0] val;
    } sched_t;

    sched_t      q[$];
    int          edge_n  = 0;
    int          emitted = 0;
    logic [31:0] exp_data = '0;
    bit          exp_vld  = 1'b0;

    function automatic int ref_act(input int x, input int t, input int c);
        int b;
        b = c % 128;
        case (t)
            0:       return (x < 0) ? 0 : x;
            1:       return (x >= 0) ? x : -((-x + 7) / 8);
            2:       return (x < 0) ? 0 : ((x > b) ? b : x);
            default: return x;
        endcase
    endfunction

    function automatic logic [31:0] ref_vec(input logic [31:0] d, input int t, input int c);
        logic [31:0] r;
        for (int k = 0; k < DS; k++) begin
            int x;
            int y;
            x = int'($signed(d[k*DW +: DW]));
            y = ref_act(x, t, c);
            r[k*DW +: DW] = y[7:0];
        end
        return r;
    endfunction

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic drive(input bit rst, input bit en, input bit v, input logic [31:0] d,
                         input logic [1:0] t, input logic [7:0] c);
        reset                 = rst;
        bus.enable_activation = en;
        bus.in_data_available = v;
        bus.inp_data          = d;
        bus.activation_type   = t;
        bus.clamp_value       = c;
        #1;
    endtask

    // Advances the reference model by one clock edge using the inputs present at that edge.
    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (reset || !bus.enable_activation) begin
            q.delete();
            emitted  = 0;
            exp_vld  = 1'b0;
            exp_data = '0;
        end else begin
            exp_vld = 1'b0;
            if (q.size() > 0 && q[0].due == edge_n) begin
                exp_vld  = 1'b1;
                exp_data = q[0].val;
                void'(q.pop_front());
                emitted++;
            end
            if (bus.in_data_available)
                q.push_back('{due: edge_n + 1,
                              val: ref_vec(bus.inp_data, int'(bus.activation_type), int'(bus.clamp_value))});
        end
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 1'b0, '0, 2'd0, 8'd0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        int seen;
        drive(1'b1, 1'b1, 1'b1, $urandom, 2'd3, 8'h7f);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, $urandom, 2'd3, 8'h7f);
            n_vec++;
            if (bus.out_data_available !== 1'b0 || bus.out_data !== 32'h0 || bus.done_activation !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: avail=%b data=%h done=%b, want 0/00000000/0",
                         i, bus.out_data_available, bus.out_data, bus.done_activation);
            end
            tick();
        end
        // Four fresh vectors: done must come with the fourth output, proving the count stayed at 0.
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, (i < 4), $urandom, 2'd3, 8'h00);
            if (bus.out_data_available === 1'b1) seen++;
            n_vec++;
            if (bus.done_activation !== (seen >= DS)) begin
                n_err++;
                $display("FAIL reset_count[%0d]: done=%b want %b (outputs seen %0d)",
                         i, bus.done_activation, (seen >= DS), seen);
            end
            tick();
        end
    endtask

    task automatic test_modes();
        logic [31:0] vin  [3];
        logic [31:0] vexp [3];
        logic [1:0]  vtype[3];
        logic [7:0]  vclmp[3];
        vin[0] = pack4(-5, 0, 7, -128);   vexp[0] = pack4(0, 0, 7, 0);
        vtype[0] = 2'd0; vclmp[0] = 8'h00;
        vin[1] = pack4(-16, -1, 9, -128); vexp[1] = pack4(-2, -1, 9, -16);
        vtype[1] = 2'd1; vclmp[1] = 8'h00;
        vin[2] = pack4(10, 6, -3, 5);     vexp[2] = pack4(6, 6, 0, 5);
        vtype[2] = 2'd2; vclmp[2] = 8'h86;
        for (int m = 0; m < 3; m++) begin
            do_reset();
            drive(1'b0, 1'b1, 1'b1, vin[m], vtype[m], vclmp[m]);
            tick();
            // Change mode right after acceptance; the in-flight vector must keep its own mode.
            drive(1'b0, 1'b1, 1'b0, $urandom, 2'd3, 8'h7f);
            n_vec++;
            if (bus.out_data_available !== 1'b0) begin
                n_err++;
                $display("FAIL mode%0d_early: avail=%b want 0", vtype[m], bus.out_data_available);
            end
            tick();
            drive(1'b0, 1'b1, 1'b0, $urandom, 2'd3, 8'h7f);
            n_vec++;
            if (bus.out_data_available !== 1'b1 || bus.out_data !== vexp[m]) begin
                n_err++;
                $display("FAIL mode%0d_result: avail=%b data=%h want 1/%h",
                         vtype[m], bus.out_data_available, bus.out_data, vexp[m]);
            end
            tick();
        end
    endtask

    task automatic test_bubbles();
        bit pat[12] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        int seen;
        do_reset();
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, pat[i], $urandom, 2'($urandom_range(0, 3)), 8'($urandom));
            if (bus.out_data_available === 1'b1) seen++;
            n_vec++;
            if (bus.out_data_available !== exp_vld || bus.done_activation !== (seen >= DS) ||
                (exp_vld && bus.out_data !== exp_data)) begin
                n_err++;
                $display("FAIL bubbles[%0d]: avail=%b done=%b data=%h want %b/%b/%h",
                         i, bus.out_data_available, bus.done_activation, bus.out_data,
                         exp_vld, (seen >= DS), exp_data);
            end
            tick();
        end
        n_vec++;
        if (seen != DS) begin
            n_err++;
            $display("FAIL bubbles_total: outputs=%0d want %0d", seen, DS);
        end
    endtask

    task automatic test_disable();
        int seen;
        logic [31:0] d;
        bit v;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, $urandom, 2'd3, 8'h00);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            v = 1'($urandom);
            drive(1'b0, 1'b0, v, d, 2'd0, 8'h00);
            n_vec++;
            if (bus.out_data !== d || bus.out_data_available !== v || bus.done_activation !== 1'b1) begin
                n_err++;
                $display("FAIL bypass[%0d]: data=%h avail=%b done=%b want %h/%b/1",
                         i, bus.out_data, bus.out_data_available, bus.done_activation, d, v);
            end
            tick();
        end
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b1, (i < 4), $urandom, 2'($urandom_range(0, 3)), 8'($urandom));
            if (bus.out_data_available === 1'b1) seen++;
            n_vec++;
            if (bus.out_data_available !== exp_vld || bus.done_activation !== (seen >= DS) ||
                (exp_vld && bus.out_data !== exp_data)) begin
                n_err++;
                $display("FAIL reenable[%0d]: avail=%b done=%b data=%h want %b/%b/%h",
                         i, bus.out_data_available, bus.done_activation, bus.out_data,
                         exp_vld, (seen >= DS), exp_data);
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit rst, en, v;
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            en  = ($urandom_range(0, 19) != 0);
            v   = ($urandom_range(0, 3) != 0);
            d   = $urandom;
            drive(rst, en, v, d, 2'($urandom_range(0, 3)), 8'($urandom));
            n_vec++;
            if (en) begin
                if (bus.out_data_available !== exp_vld || bus.done_activation !== (emitted >= DS) ||
                    (exp_vld && bus.out_data !== exp_data)) begin
                    n_err++;
                    $display("FAIL random[%0d]: avail=%b done=%b data=%h want %b/%b/%h",
                             i, bus.out_data_available, bus.done_activation, bus.out_data,
                             exp_vld, (emitted >= DS), exp_data);
                end
            end else begin
                if (bus.out_data !== d || bus.out_data_available !== v || bus.done_activation !== 1'b1) begin
                    n_err++;
                    $display("FAIL random_bypass[%0d]: data=%h avail=%b done=%b want %h/%b/1",
                             i, bus.out_data, bus.out_data_available, bus.done_activation, d, v);
                end
            end
            tick();
        end
    endtask

    initial begin
        reset                 = 1'b1;
        bus.enable_activation = 1'b1;
        bus.in_data_available = 1'b0;
        bus.inp_data          = '0;
        bus.activation_type   = 2'd0;
        bus.clamp_value       = '0;
        test_reset();
        test_modes();
        test_bubbles();
        test_disable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
